// File: rtl/batch_issue_sequencer_pkg.sv
// Shared widths, read latency and FSM state encoding for the batch issue sequencer.
package batch_issue_sequencer_pkg;

  localparam int REQUEST_ID_WIDTH = 6;
  localparam int SRR_ID_WIDTH     = 5;
  localparam int SBR_ID_WIDTH     = 4;
  localparam int TABLE_RD_LAT     = 2;
  localparam int STALL_W          = 16;

  typedef enum logic [2:0] {
    ISSUE_IDLE   = 3'd0,
    ISSUE_RD_SBR = 3'd1,
    ISSUE_RD_SRR = 3'd2,
    ISSUE_ISSUE  = 3'd3,
    ISSUE_RD_REQ = 3'd4,
    ISSUE_DONE   = 3'd5
  } issue_state_e;

endpackage

// File: rtl/batch_issue_sequencer_if.sv
// Issue handshake towards the DRAM command generator (valid/ready plus request tags).
interface batch_issue_sequencer_if
  import batch_issue_sequencer_pkg::*;
#(
  parameter int REQ_ID_W = REQUEST_ID_WIDTH
) ();

  logic                iss_valid;
  logic                iss_ready;
  logic [REQ_ID_W-1:0] iss_req_id;
  logic                iss_row_first;
  logic                iss_last;

  modport master (
    output iss_valid, iss_req_id, iss_row_first, iss_last,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_req_id, iss_row_first, iss_last,
    output iss_ready
  );

endinterface

// File: rtl/batch_issue_sequencer_table_read_waiter.sv
// Countdown shared by all table reads: data_valid_o fires RD_LAT cycles after the
// address register updated by launch_i becomes visible.
module table_read_waiter #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch_i,
  output logic data_valid_o
);

  localparam logic [2:0] LOAD_VAL = 3'(RD_LAT + 1);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // next count: reload on launch, otherwise run down to zero and rest there
  always_comb begin
    cnt_d = cnt_q;
    if (launch_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = 3'd0;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign data_valid_o = (cnt_q == 3'd1);

endmodule

// File: rtl/batch_issue_sequencer.sv
// Walks SBR -> SRR chain -> request chain and issues request IDs one at a time.
// Optional per-batch statistics outputs are built when BATCH_ISSUE_STATS_EN is defined.
module batch_issue_sequencer
  import batch_issue_sequencer_pkg::*;
#(
  parameter int REQ_ID_W = REQUEST_ID_WIDTH,
  parameter int SRR_ID_W = SRR_ID_WIDTH,
  parameter int SBR_ID_W = SBR_ID_WIDTH,
  parameter int RD_LAT   = TABLE_RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SBR_ID_W-1:0] critical_sbr,
  output logic                busy,
  output logic                done,
`ifdef BATCH_ISSUE_STATS_EN
  output logic [REQ_ID_W-1:0] stat_issued,
  output logic [STALL_W-1:0]  stat_stall,
`endif
  output logic [SBR_ID_W-1:0] sbr_rd_addr,
  input  logic [SRR_ID_W-1:0] sbr_rd_head_srr,
  input  logic [SRR_ID_W-1:0] sbr_rd_row_count,
  output logic [SRR_ID_W-1:0] srr_rd_addr,
  input  logic [REQ_ID_W-1:0] srr_rd_head_req,
  input  logic [REQ_ID_W-1:0] srr_rd_count,
  input  logic [SRR_ID_W-1:0] srr_rd_next,
  output logic [REQ_ID_W-1:0] req_rd_addr,
  input  logic [REQ_ID_W-1:0] req_rd_next,
  batch_issue_sequencer_if.master iss_if
);

  issue_state_e        state_q, state_d;
  logic [SBR_ID_W-1:0] sbr_addr_q, sbr_addr_d;
  logic [SRR_ID_W-1:0] srr_addr_q, srr_addr_d;
  logic [REQ_ID_W-1:0] req_addr_q, req_addr_d;
  logic [SRR_ID_W-1:0] srr_ptr_q, srr_ptr_d, next_srr_q, next_srr_d;
  logic [SRR_ID_W-1:0] rows_left_q, rows_left_d;
  logic [REQ_ID_W-1:0] req_ptr_q, req_ptr_d, reqs_left_q, reqs_left_d;
  logic                row_first_q, row_first_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                iss_valid_q, iss_valid_d, iss_first_q, iss_first_d;
  logic                iss_last_q, iss_last_d;
  logic [REQ_ID_W-1:0] iss_id_q, iss_id_d;
  logic                launch_s, dv_s, hs_s;

  table_read_waiter #(.RD_LAT(RD_LAT)) u_waiter (
    .clk          (clk),
    .rst_n        (rst_n),
    .launch_i     (launch_s),
    .data_valid_o (dv_s)
  );

  assign hs_s = iss_valid_q && iss_if.iss_ready;

  // next-state, table addressing and registered-output values
  always_comb begin
    state_d     = state_q;
    sbr_addr_d  = sbr_addr_q;
    srr_addr_d  = srr_addr_q;
    req_addr_d  = req_addr_q;
    srr_ptr_d   = srr_ptr_q;
    next_srr_d  = next_srr_q;
    rows_left_d = rows_left_q;
    req_ptr_d   = req_ptr_q;
    reqs_left_d = reqs_left_q;
    row_first_d = row_first_q;
    launch_s    = 1'b0;
    case (state_q)
      ISSUE_IDLE: begin
        if (start) begin
          state_d    = ISSUE_RD_SBR;
          sbr_addr_d = critical_sbr;
          launch_s   = 1'b1;
        end else begin
          state_d = ISSUE_IDLE;
        end
      end
      ISSUE_RD_SBR: begin
        if (dv_s) begin
          srr_ptr_d   = sbr_rd_head_srr;
          rows_left_d = sbr_rd_row_count;
          if (sbr_rd_row_count == SRR_ID_W'(0)) begin
            state_d = ISSUE_DONE;
          end else begin
            state_d    = ISSUE_RD_SRR;
            srr_addr_d = sbr_rd_head_srr;
            launch_s   = 1'b1;
          end
        end else begin
          state_d = ISSUE_RD_SBR;
        end
      end
      ISSUE_RD_SRR: begin
        if (dv_s) begin
          req_ptr_d   = srr_rd_head_req;
          reqs_left_d = srr_rd_count;
          next_srr_d  = srr_rd_next;
          row_first_d = 1'b1;
          if (srr_rd_count != REQ_ID_W'(0)) begin
            state_d = ISSUE_ISSUE;
          end else if (rows_left_q > SRR_ID_W'(1)) begin
            // empty SRR: skip straight to the next one in the chain
            rows_left_d = rows_left_q - SRR_ID_W'(1);
            srr_ptr_d   = srr_rd_next;
            srr_addr_d  = srr_rd_next;
            launch_s    = 1'b1;
            state_d     = ISSUE_RD_SRR;
          end else begin
            rows_left_d = rows_left_q - SRR_ID_W'(1);
            state_d     = ISSUE_DONE;
          end
        end else begin
          state_d = ISSUE_RD_SRR;
        end
      end
      ISSUE_ISSUE: begin
        if (hs_s) begin
          row_first_d = 1'b0;
          reqs_left_d = reqs_left_q - REQ_ID_W'(1);
          if (reqs_left_q > REQ_ID_W'(1)) begin
            state_d    = ISSUE_RD_REQ;
            req_addr_d = req_ptr_q;
            launch_s   = 1'b1;
          end else if (rows_left_q > SRR_ID_W'(1)) begin
            rows_left_d = rows_left_q - SRR_ID_W'(1);
            srr_ptr_d   = next_srr_q;
            srr_addr_d  = next_srr_q;
            launch_s    = 1'b1;
            state_d     = ISSUE_RD_SRR;
          end else begin
            rows_left_d = rows_left_q - SRR_ID_W'(1);
            state_d     = ISSUE_DONE;
          end
        end else begin
          state_d = ISSUE_ISSUE;
        end
      end
      ISSUE_RD_REQ: begin
        if (dv_s) begin
          req_ptr_d = req_rd_next;
          state_d   = ISSUE_ISSUE;
        end else begin
          state_d = ISSUE_RD_REQ;
        end
      end
      ISSUE_DONE: begin
        state_d = ISSUE_IDLE;
      end
      default: begin
        state_d = ISSUE_IDLE;
      end
    endcase
    busy_d      = (state_d != ISSUE_IDLE) && (state_d != ISSUE_DONE);
    done_d      = (state_d == ISSUE_DONE);
    iss_valid_d = (state_d == ISSUE_ISSUE);
    iss_id_d    = iss_valid_d ? req_ptr_d : REQ_ID_W'(0);
    iss_first_d = iss_valid_d && row_first_d;
    iss_last_d  = iss_valid_d && (rows_left_d == SRR_ID_W'(1)) && (reqs_left_d == REQ_ID_W'(1));
  end

  // state, walk context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ISSUE_IDLE;
      sbr_addr_q  <= SBR_ID_W'(0);
      srr_addr_q  <= SRR_ID_W'(0);
      req_addr_q  <= REQ_ID_W'(0);
      srr_ptr_q   <= SRR_ID_W'(0);
      next_srr_q  <= SRR_ID_W'(0);
      rows_left_q <= SRR_ID_W'(0);
      req_ptr_q   <= REQ_ID_W'(0);
      reqs_left_q <= REQ_ID_W'(0);
      row_first_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_id_q    <= REQ_ID_W'(0);
      iss_first_q <= 1'b0;
      iss_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sbr_addr_q  <= sbr_addr_d;
      srr_addr_q  <= srr_addr_d;
      req_addr_q  <= req_addr_d;
      srr_ptr_q   <= srr_ptr_d;
      next_srr_q  <= next_srr_d;
      rows_left_q <= rows_left_d;
      req_ptr_q   <= req_ptr_d;
      reqs_left_q <= reqs_left_d;
      row_first_q <= row_first_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      iss_valid_q <= iss_valid_d;
      iss_id_q    <= iss_id_d;
      iss_first_q <= iss_first_d;
      iss_last_q  <= iss_last_d;
    end
  end

`ifdef BATCH_ISSUE_STATS_EN
  logic [REQ_ID_W-1:0] stat_issued_q;
  logic [STALL_W-1:0]  stat_stall_q;
  logic                start_acc_s;

  assign start_acc_s = (state_q == ISSUE_IDLE) && start;

  // per-batch handshake and stall counters, cleared when a batch is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= REQ_ID_W'(0);
      stat_stall_q  <= STALL_W'(0);
    end else if (start_acc_s) begin
      stat_issued_q <= REQ_ID_W'(0);
      stat_stall_q  <= STALL_W'(0);
    end else begin
      if (hs_s) begin
        stat_issued_q <= stat_issued_q + REQ_ID_W'(1);
      end
      if (iss_valid_q && !iss_if.iss_ready && (stat_stall_q != {STALL_W{1'b1}})) begin
        stat_stall_q <= stat_stall_q + STALL_W'(1);
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign sbr_rd_addr          = sbr_addr_q;
  assign srr_rd_addr          = srr_addr_q;
  assign req_rd_addr          = req_addr_q;
  assign iss_if.iss_valid     = iss_valid_q;
  assign iss_if.iss_req_id    = iss_id_q;
  assign iss_if.iss_row_first = iss_first_q;
  assign iss_if.iss_last      = iss_last_q;

endmodule

// File: tb/tb_batch_issue_sequencer.sv
// Directed bench for batch_issue_sequencer: table models with RD_LAT pipelines,
// expected issues queued by the stimulus and checked by an independent monitor.
module tb_batch_issue_sequencer;
  import batch_issue_sequencer_pkg::*;

  localparam int RQW = 6;
  localparam int SRW = 5;
  localparam int SBW = 4;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [SBW-1:0] critical_sbr = '0;
  logic           busy, done;
  logic [SBW-1:0] sbr_rd_addr;
  logic [SRW-1:0] sbr_rd_head_srr, sbr_rd_row_count, srr_rd_addr, srr_rd_next;
  logic [RQW-1:0] srr_rd_head_req, srr_rd_count, req_rd_addr, req_rd_next;
`ifdef BATCH_ISSUE_STATS_EN
  logic [RQW-1:0] stat_issued;
  logic [15:0]    stat_stall;
`endif

  batch_issue_sequencer_if #(.REQ_ID_W(RQW)) iss_if ();

  batch_issue_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .critical_sbr     (critical_sbr),
    .busy             (busy),
    .done             (done),
`ifdef BATCH_ISSUE_STATS_EN
    .stat_issued      (stat_issued),
    .stat_stall       (stat_stall),
`endif
    .sbr_rd_addr      (sbr_rd_addr),
    .sbr_rd_head_srr  (sbr_rd_head_srr),
    .sbr_rd_row_count (sbr_rd_row_count),
    .srr_rd_addr      (srr_rd_addr),
    .srr_rd_head_req  (srr_rd_head_req),
    .srr_rd_count     (srr_rd_count),
    .srr_rd_next      (srr_rd_next),
    .req_rd_addr      (req_rd_addr),
    .req_rd_next      (req_rd_next),
    .iss_if           (iss_if)
  );

  always #5 clk = ~clk;

  // table contents and read pipelines (address seen in cycle T -> data in T+2)
  logic [SRW-1:0]         sbr_head_m [16];
  logic [SRW-1:0]         sbr_rows_m [16];
  logic [RQW-1:0]         srr_head_m [32];
  logic [RQW-1:0]         srr_cnt_m  [32];
  logic [SRW-1:0]         srr_next_m [32];
  logic [RQW-1:0]         req_next_m [64];
  logic [2*SRW-1:0]       sbr_p1, sbr_p2;
  logic [2*RQW+SRW-1:0]   srr_p1, srr_p2;
  logic [RQW-1:0]         req_p1, req_p2;

  always @(posedge clk) begin
    sbr_p1 <= {sbr_head_m[sbr_rd_addr], sbr_rows_m[sbr_rd_addr]};
    sbr_p2 <= sbr_p1;
    srr_p1 <= {srr_head_m[srr_rd_addr], srr_cnt_m[srr_rd_addr], srr_next_m[srr_rd_addr]};
    srr_p2 <= srr_p1;
    req_p1 <= req_next_m[req_rd_addr];
    req_p2 <= req_p1;
  end
  assign {sbr_rd_head_srr, sbr_rd_row_count}          = sbr_p2;
  assign {srr_rd_head_req, srr_rd_count, srr_rd_next} = srr_p2;
  assign req_rd_next                                  = req_p2;

  typedef struct packed {
    logic [RQW-1:0] id;
    logic           first;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic first, input logic last);
    exp_t e;
    e.id = RQW'(id);
    e.first = first;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_batch_a();
    push(5, 1'b1, 1'b0);
    push(9, 1'b0, 1'b0);
    push(12, 1'b0, 1'b0);
    push(20, 1'b1, 1'b1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: scoreboard pop on handshake, stability while stalled, done tracking
  logic           prev_hold = 1'b0;
  logic [RQW-1:0] prev_id;
  logic           prev_first, prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", iss_if.iss_valid, 1);
        check("hold_id", iss_if.iss_req_id, prev_id);
        check("hold_first", iss_if.iss_row_first, prev_first);
        check("hold_last", iss_if.iss_last, prev_last);
      end
      if (iss_if.iss_valid && iss_if.iss_ready) begin
        check("issue_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("issue_id", iss_if.iss_req_id, e.id);
          check("issue_row_first", iss_if.iss_row_first, e.first);
          check("issue_last", iss_if.iss_last, e.last);
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      prev_hold  <= iss_if.iss_valid && !iss_if.iss_ready;
      prev_id    <= iss_if.iss_req_id;
      prev_first <= iss_if.iss_row_first;
      prev_last  <= iss_if.iss_last;
    end
  end

  task automatic run_batch(input logic [SBW-1:0] sbr, input int stall_id, input int stall_n,
                           input int extra_start_at, output int s_cyc);
    int d0;
    int stalls;
    int k;
    d0 = done_cnt;
    stalls = 0;
    k = 0;
    @(posedge clk); #1;
    critical_sbr = sbr;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    critical_sbr = '0;
    check("busy_after_start", busy, 1);
    while (done_cnt == d0 && k < 200) begin
      if (k == extra_start_at) begin
        start = 1'b1;
        critical_sbr = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (iss_if.iss_valid && int'(iss_if.iss_req_id) == stall_id && stalls < stall_n) begin
        iss_if.iss_ready = 1'b0;
        stalls++;
      end else begin
        iss_if.iss_ready = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    iss_if.iss_ready = 1'b1;
    check("done_seen", done_cnt - d0, 1);
    repeat (6) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int s_cyc;
    int seen9;
    for (int i = 0; i < 16; i++) begin
      sbr_head_m[i] = '0;
      sbr_rows_m[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      srr_head_m[i] = '0;
      srr_cnt_m[i]  = '0;
      srr_next_m[i] = '0;
    end
    for (int i = 0; i < 64; i++) req_next_m[i] = 6'd63;
    // batch A: SBR 3 -> SRR 4 (5,9,12) -> SRR 7 (20); trailing links are stale
    sbr_head_m[3] = 5'd4;  sbr_rows_m[3] = 5'd2;
    srr_head_m[4] = 6'd5;  srr_cnt_m[4] = 6'd3; srr_next_m[4] = 5'd7;
    srr_head_m[7] = 6'd20; srr_cnt_m[7] = 6'd1; srr_next_m[7] = 5'd30;
    req_next_m[5] = 6'd9;  req_next_m[9] = 6'd12; req_next_m[12] = 6'd33;
    // empty batch
    sbr_head_m[1] = 5'd6;  sbr_rows_m[1] = 5'd0;
    // batch with an empty SRR in the middle: SRR 10 (40), SRR 11 (none), SRR 12 (41)
    sbr_head_m[2] = 5'd10; sbr_rows_m[2] = 5'd3;
    srr_head_m[10] = 6'd40; srr_cnt_m[10] = 6'd1; srr_next_m[10] = 5'd11;
    srr_head_m[11] = 6'd50; srr_cnt_m[11] = 6'd0; srr_next_m[11] = 5'd12;
    srr_head_m[12] = 6'd41; srr_cnt_m[12] = 6'd1; srr_next_m[12] = 5'd0;
    iss_if.iss_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", iss_if.iss_valid, 0);
    check("rst_id", iss_if.iss_req_id, 0);
    check("rst_sbr_addr", sbr_rd_addr, 0);
    check("rst_srr_addr", srr_rd_addr, 0);
    check("rst_req_addr", req_rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    push_batch_a();
    run_batch(4'd3, -1, 0, -1, s_cyc);
`ifdef BATCH_ISSUE_STATS_EN
    check("stat_issued_a", stat_issued, 4);
    check("stat_stall_a", stat_stall, 0);
`endif

    push_batch_a();
    run_batch(4'd3, 9, 4, -1, s_cyc);
`ifdef BATCH_ISSUE_STATS_EN
    check("stat_issued_stall", stat_issued, 4);
    check("stat_stall_stall", stat_stall, 4);
`endif

    run_batch(4'd1, -1, 0, -1, s_cyc);
    check("zero_done_latency", done_cyc - s_cyc, LAT + 2);
`ifdef BATCH_ISSUE_STATS_EN
    check("stat_issued_zero", stat_issued, 0);
    check("stat_stall_zero", stat_stall, 0);
`endif

    push(40, 1'b1, 1'b0);
    push(41, 1'b1, 1'b1);
    run_batch(4'd2, -1, 0, -1, s_cyc);

    // reset while request 9 is waiting for ready
    push_batch_a();
    @(posedge clk); #1;
    critical_sbr = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen9 = 0;
    for (int k = 0; k < 100 && seen9 < 2; k++) begin
      if (iss_if.iss_valid && iss_if.iss_req_id == 6'd9) begin
        iss_if.iss_ready = 1'b0;
        seen9++;
      end else begin
        iss_if.iss_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("reset_reached_req9", seen9, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", iss_if.iss_valid, 0);
    check("midrst_id", iss_if.iss_req_id, 0);
    check("midrst_first", iss_if.iss_row_first, 0);
    check("midrst_last", iss_if.iss_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_srr_addr", srr_rd_addr, 0);
    check("midrst_req_addr", req_rd_addr, 0);
    check("midrst_pending", exp_q.size(), 3);
    exp_q.delete();
    iss_if.iss_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_batch_a();
    run_batch(4'd3, -1, 0, -1, s_cyc);

    // start pulsed mid-batch must be ignored
    push_batch_a();
    run_batch(4'd3, -1, 0, 3, s_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
